branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
Execute-stage branch resolution unit sitting directly downstream of the add/sub/compare unit in the RV32I core. It consumes the comparator's subtract result and flags (rs1 driven on dIn0, rs2 on dIn1), evaluates the conditional branch selected by funct3, computes jump and branch targets, and registers a single redirect/link result behind a valid/ready handshake. After every taken redirect it squashes a fixed number of wrong-path instructions.

Parameters:
XLEN, 32, datapath width.
SQUASH_DEPTH, 2, number of accepted instructions dropped after a redirect (fetch and decode in flight).

Ports:
clk  input  1  core clock, rising edge.
rstN  input  1  asynchronous active-low reset.
inValid  input  1  upstream instruction valid.
inReady  output  1  unit can accept this cycle.
isBranch  input  1  conditional branch (BEQ..BGEU).
isJal  input  1  JAL.
isJalr  input  1  JALR.
funct3  input  3  branch condition select.
pc  input  XLEN  instruction PC.
imm  input  XLEN  sign-extended immediate.
rs1Val  input  XLEN  rs1 value (JALR base).
rs1Msb  input  1  rs1[XLEN-1].
rs2Msb  input  1  rs2[XLEN-1].
sub  input  XLEN  comparator rs1 - rs2.
overflowSub  input  1  comparator subtract overflow.
equal  input  1  comparator equal flag.
outValid  output  1  registered result valid.
outReady  input  1  downstream accepts result.
redirect  output  1  taken branch/jump, fetch must load redirectPc.
redirectPc  output  XLEN  target address.
linkVal  output  XLEN  pc+4 for JAL/JALR rd write.
misaligned  output  1  taken target with target[1:0] != 0; redirect forced 0.
squashing  output  1  unit is dropping wrong-path instructions.

Behaviour:
- Clock clk; reset rstN asynchronous, active low. Reset: outValid=0, redirect=0, misaligned=0, redirectPc=0, linkVal=0, squashing=0, squash counter=0, state IDLE.
- Handshake: transfer in when inValid & inReady; inReady = ~outValid | outReady (single-entry pipeline register, full throughput, latency 1 cycle). Result held stable while outValid & ~outReady.
- Condition (funct3): 000 BEQ = equal; 001 BNE = ~equal; 100 BLT = sub[XLEN-1] ^ overflowSub; 101 BGE = ~BLT; 110 BLTU = (rs1Msb != rs2Msb) ? rs2Msb : (sub[XLEN-1] ^ overflowSub); 111 BGEU = ~BLTU; 010/011 never taken.
- Signed result must not use the raw sign of sub alone; overflow correction is mandatory.
- Targets: branch/JAL = pc + imm; JALR = (rs1Val + imm) & ~1; all mod 2^XLEN, wrap silently. linkVal = pc + 4 (wraps).
- taken = isJal | isJalr | (isBranch & cond). If taken and target[1:0] != 0: misaligned=1, redirect=0, no squash. Non-control instruction: outValid=1, redirect=0, misaligned=0.
- Priority when more than one of isJal/isJalr/isBranch set: isJalr > isJal > isBranch.
- States: IDLE, SQUASH. IDLE: accepted taken, aligned instruction -> load counter SQUASH_DEPTH, go SQUASH. SQUASH: each accepted instruction is consumed (inReady still follows rule above) but produces no output (outValid not set), counter decrements; counter reaching 0 -> IDLE. squashing = (state == SQUASH).
- SQUASH_DEPTH = 0: never enter SQUASH.
- Redirect pulse: redirect is valid only while outValid; downstream sees it once per handshake.
- Reset mid-squash or with a held result: immediate return to reset values; pending result lost.

Decomposition:
- Shared package/header: funct3 branch encodings (BEQ..BGEU), XLEN default, state encodings IDLE/SQUASH.
- One natural sub-module: branch_cond (pure combinational funct3/flag evaluation), unit-testable on its own; target adders inline.

Test Plan:
- BLT rs1=0x7FFFFFFF, rs2=0x80000000 (sub=0xFFFFFFFF, overflowSub=1), pc=0x100, imm=0x20 -> not taken, outValid=1, redirect=0 one cycle later.
- BLTU rs1=0x00000001, rs2=0xFFFFFFFF -> taken, redirectPc=0x120, squashing=1; next two accepted instructions produce no outValid, third produces output.
- JALR rs1Val=0x1003, imm=0x4 -> redirectPc=0x1006 (bit0 cleared), misaligned=1, redirect=0, squashing stays 0, linkVal=pc+4.
- JAL pc=0xFFFFFFFC, imm=0x8 -> redirectPc=0x00000004 (wrap), linkVal=0x00000000.
- Backpressure: outReady=0 for 3 cycles with result held -> inReady=0, outputs stable; outReady=1 -> new instruction accepted same cycle.
- Assert rstN=0 mid-SQUASH with outValid=1 -> all outputs 0 immediately (asynchronous), squashing=0, next instruction after release processed normally.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the execute-stage branch resolution unit.
package branch_resolve_pkg;

  localparam int XLEN_DEFAULT         = 32;
  localparam int SQUASH_DEPTH_DEFAULT = 2;

  // RV32I conditional-branch funct3 encodings (010/011 are unused).
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branchFunct3_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } resolveState_e;

endpackage

// File: rtl/branch_cond.sv
// Conditional branch evaluation from the comparator's subtract flags.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       subMsb,
  input  logic       overflowSub,
  input  logic       equal,
  input  logic       rs1Msb,
  input  logic       rs2Msb,
  output logic       cond
);

  logic lessSigned;
  logic lessUnsigned;

  // Signed less-than needs the overflow correction; unsigned resolves on
  // differing MSBs first, otherwise the signed result is already exact.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cond         = 1'b0;
    lessSigned   = subMsb ^ overflowSub;
    lessUnsigned = (rs1Msb != rs2Msb) ? rs2Msb : lessSigned;
    case (funct3)
      F3_BEQ:  cond = equal;
      F3_BNE:  cond = ~equal;
      F3_BLT:  cond = lessSigned;
      F3_BGE:  cond = ~lessSigned;
      F3_BLTU: cond = lessUnsigned;
      F3_BGEU: cond = ~lessUnsigned;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: evaluates branch/jump, registers a single
// redirect/link result behind valid/ready, then drops wrong-path instructions.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int SQUASH_DEPTH = SQUASH_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  logic            isBranch,
  input  logic            isJal,
  input  logic            isJalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1Val,
  input  logic            rs1Msb,
  input  logic            rs2Msb,
  input  logic [XLEN-1:0] sub,
  input  logic            overflowSub,
  input  logic            equal,
  output logic            outValid,
  input  logic            outReady,
  output logic            redirect,
  output logic [XLEN-1:0] redirectPc,
  output logic [XLEN-1:0] linkVal,
  output logic            misaligned,
  output logic            squashing
);

  localparam int CW = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  resolveState_e   state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            accept;
  logic            loadResult;
  logic            cond;
  logic            taken;
  logic            targetMisaligned;
  logic [XLEN-1:0] pcTarget;
  logic [XLEN-1:0] jalrTarget;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pcPlus4;

  // Only the sign of the comparator difference is consumed here.
  logic            unusedSub;
  assign unusedSub = ^sub[XLEN-2:0];

  branch_cond uCond (
    .funct3      (funct3),
    .subMsb      (sub[XLEN-1]),
    .overflowSub (overflowSub),
    .equal       (equal),
    .rs1Msb      (rs1Msb),
    .rs2Msb      (rs2Msb),
    .cond        (cond)
  );

  assign inReady   = ~outValid | outReady;
  assign accept    = inValid & inReady;
  assign squashing = (state == SQUASH);

  // Target adders: JALR clears bit 0; everything wraps modulo 2^XLEN.
  assign pcTarget         = pc + imm;
  assign jalrTarget       = (rs1Val + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign target           = isJalr ? jalrTarget : pcTarget;
  assign pcPlus4          = pc + XLEN'(4);
  assign taken            = isJalr | isJal | (isBranch & cond);
  assign targetMisaligned = taken & (target[1:0] != 2'b00);

  // Next state: taken aligned redirect starts a squash window; each accepted
  // instruction in the window is consumed silently.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    loadResult = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          loadResult = 1'b1;
          if (taken && !targetMisaligned && SQUASH_DEPTH != 0) begin
            stateNext = SQUASH;
            cntNext   = CW'(SQUASH_DEPTH);
          end
        end
      end
      SQUASH: begin
        if (accept) begin
          cntNext = cnt - CW'(1);
          if (cnt <= CW'(1)) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and squash counter registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Single-entry result register; held while downstream stalls.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      outValid   <= 1'b0;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
      redirectPc <= '0;
      linkVal    <= '0;
    end else if (loadResult) begin
      outValid   <= 1'b1;
      redirect   <= taken & ~targetMisaligned;
      misaligned <= targetMisaligned;
      redirectPc <= target;
      linkVal    <= pcPlus4;
    end else if (outReady) begin
      outValid   <= 1'b0;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic        isBranch;
  logic        isJal;
  logic        isJalr;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rs1Val;
  logic        rs1Msb;
  logic        rs2Msb;
  logic [31:0] sub;
  logic        overflowSub;
  logic        equal;
  logic        outValid;
  logic        outReady;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] linkVal;
  logic        misaligned;
  logic        squashing;

  int passCount  = 0;
  int totalCount = 0;

  branch_resolve dut (
    .clk         (clk),
    .rstN        (rstN),
    .inValid     (inValid),
    .inReady     (inReady),
    .isBranch    (isBranch),
    .isJal       (isJal),
    .isJalr      (isJalr),
    .funct3      (funct3),
    .pc          (pc),
    .imm         (imm),
    .rs1Val      (rs1Val),
    .rs1Msb      (rs1Msb),
    .rs2Msb      (rs2Msb),
    .sub         (sub),
    .overflowSub (overflowSub),
    .equal       (equal),
    .outValid    (outValid),
    .outReady    (outReady),
    .redirect    (redirect),
    .redirectPc  (redirectPc),
    .linkVal     (linkVal),
    .misaligned  (misaligned),
    .squashing   (squashing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  // Drive one instruction, modelling the upstream comparator from rs1/rs2.
  task automatic drive(input logic v, input logic b, input logic j, input logic jr,
                       input logic [2:0] f, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] d;
    d           = r1 - r2;
    inValid     = v;
    isBranch    = b;
    isJal       = j;
    isJalr      = jr;
    funct3      = f;
    pc          = p;
    imm         = i;
    rs1Val      = r1;
    rs1Msb      = r1[31];
    rs2Msb      = r2[31];
    sub         = d;
    overflowSub = (r1[31] != r2[31]) && (d[31] != r1[31]);
    equal       = (r1 == r2);
  endtask

  task automatic plain(input logic [31:0] p);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, p, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN     = 1'b0;
    outReady = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    #12;
    check("rst_outValid", outValid, 0);
    check("rst_redirect", redirect, 0);
    check("rst_redirectPc", redirectPc, 0);
    check("rst_linkVal", linkVal, 0);
    check("rst_squashing", squashing, 0);
    check("rst_inReady", inReady, 1);
    @(negedge clk);
    rstN = 1'b1;
    step();

    // BLT with signed overflow: 0x7FFFFFFF < 0x80000000 is false signed.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h100, 32'h20, 32'h7FFFFFFF, 32'h80000000);
    step();
    check("blt_outValid", outValid, 1);
    check("blt_redirect", redirect, 0);
    check("blt_misaligned", misaligned, 0);
    check("blt_linkVal", linkVal, 32'h104);
    check("blt_squashing", squashing, 0);

    // BGE 0x80000000 vs 1: rs1 is negative, so not taken.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h100, 32'h20, 32'h80000000, 32'h1);
    step();
    check("bge_redirect", redirect, 0);

    // Unused funct3 010 with equal operands never branches.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h20, 32'h5, 32'h5);
    step();
    check("f3_010_redirect", redirect, 0);

    // BLTU 1 < 0xFFFFFFFF: taken, squash window of two.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h100, 32'h20, 32'h1, 32'hFFFFFFFF);
    step();
    check("bltu_outValid", outValid, 1);
    check("bltu_redirect", redirect, 1);
    check("bltu_redirectPc", redirectPc, 32'h120);
    check("bltu_squashing", squashing, 1);
    plain(32'h200);
    step();
    check("sq1_outValid", outValid, 0);
    check("sq1_squashing", squashing, 1);
    plain(32'h204);
    step();
    check("sq2_outValid", outValid, 0);
    check("sq2_squashing", squashing, 0);
    plain(32'h208);
    step();
    check("post_outValid", outValid, 1);
    check("post_redirect", redirect, 0);
    check("post_linkVal", linkVal, 32'h20C);

    // JALR with misaligned target: bit 0 cleared, bit 1 set.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h300, 32'h4, 32'h1003, 32'h0);
    step();
    check("jalr_redirectPc", redirectPc, 32'h1006);
    check("jalr_misaligned", misaligned, 1);
    check("jalr_redirect", redirect, 0);
    check("jalr_squashing", squashing, 0);
    check("jalr_linkVal", linkVal, 32'h304);

    // JAL with wrapping target and link.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0);
    step();
    check("jal_redirect", redirect, 1);
    check("jal_redirectPc", redirectPc, 32'h4);
    check("jal_linkVal", linkVal, 32'h0);
    check("jal_squashing", squashing, 1);
    plain(32'h210);
    step();
    plain(32'h214);
    step();
    check("jal_drain_squashing", squashing, 0);

    // Backpressure: result held while outReady is low.
    outReady = 1'b0;
    plain(32'h400);
    step();
    check("bp_outValid", outValid, 1);
    check("bp_linkVal", linkVal, 32'h404);
    plain(32'h500);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_inReady_low", inReady, 0);
      step();
      check("bp_hold_outValid", outValid, 1);
      check("bp_hold_linkVal", linkVal, 32'h404);
    end
    outReady = 1'b1;
    #1;
    check("bp_inReady_high", inReady, 1);
    step();
    check("bp_new_outValid", outValid, 1);
    check("bp_new_linkVal", linkVal, 32'h504);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    check("bp_drain_outValid", outValid, 0);

    // Asynchronous reset mid-squash with a held result.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h600, 32'h40, 32'h5, 32'h5);
    step();
    check("beq_redirect", redirect, 1);
    check("beq_redirectPc", redirectPc, 32'h640);
    check("beq_squashing", squashing, 1);
    outReady = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    rstN = 1'b0;
    #1;
    check("arst_outValid", outValid, 0);
    check("arst_redirect", redirect, 0);
    check("arst_redirectPc", redirectPc, 0);
    check("arst_linkVal", linkVal, 0);
    check("arst_squashing", squashing, 0);
    @(negedge clk);
    rstN     = 1'b1;
    outReady = 1'b1;
    step();
    plain(32'h700);
    step();
    check("after_rst_outValid", outValid, 1);
    check("after_rst_linkVal", linkVal, 32'h704);
    check("after_rst_squashing", squashing, 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
